pipe_ctrl: RTL and testbench

Central pipeline control for the 5-stage core (IF, ID, EX, MEM, WB). It generates en/stall/flush for the four inter-stage register slices (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write/select. It resolves memory wait, multi-cycle EX, load-use, branch redirect and trap. It also discards stale in-flight fetches and keeps stall/flush performance counters.

---
 rtl/pipe_ctrl_if.sv | 60 ++++++
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_if
// Purpose  : Bundle of hazard inputs and control outputs between the
//            pipeline control block and the 5-stage datapath.
// Modports : master - pipeline control (reads hazards, drives controls)
//            slave  - datapath side (drives hazards, reads controls)
// Signals  : if_ready, {id,ex,mem,wb}_valid, id_rs1/rs2, id_use_rs1/rs2,
//            ex_rd, ex_is_load, ex_busy, ex_redirect, mem_req, mem_ready,
//            wb_trap -> control; pc_we, pc_sel, slice_en/stall/flush,
//            if_kill, perf_stall_cnt, perf_flush_cnt <- control
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 32
);
  logic                  if_ready;
  logic                  id_valid;
  logic                  ex_valid;
  logic                  mem_valid;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_is_load;
  logic                  ex_busy;
  logic                  ex_redirect;
  logic                  mem_req;
  logic                  mem_ready;
  logic                  wb_trap;

  logic                  pc_we;
  logic [1:0]            pc_sel;
  logic [3:0]            slice_en;
  logic [3:0]            slice_stall;
  logic [3:0]            slice_flush;
  logic                  if_kill;
  logic [CNT_WIDTH-1:0]  perf_stall_cnt;
  logic [CNT_WIDTH-1:0]  perf_flush_cnt;

  modport master (
    input  if_ready, id_valid, ex_valid, mem_valid, wb_valid,
           id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_busy, ex_redirect, mem_req, mem_ready, wb_trap,
    output pc_we, pc_sel, slice_en, slice_stall, slice_flush, if_kill,
           perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    output if_ready, id_valid, ex_valid, mem_valid, wb_valid,
           id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_busy, ex_redirect, mem_req, mem_ready, wb_trap,
    input  pc_we, pc_sel, slice_en, slice_stall, slice_flush, if_kill,
           perf_stall_cnt, perf_flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Central pipeline control for the IF/ID/EX/MEM/WB core. Resolves
//            trap, memory wait, multi-cycle EX, branch redirect and load-use
//            hazards into per-slice en/stall/flush plus PC write/select,
//            drops stale in-flight fetches after a redirect, and counts
//            stall cycles and flush events.
// Ports    : clk, rst (synchronous, active-high)
//            bus (pipe_ctrl_if.master) - hazard inputs / control outputs
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  wire logic   clk,
  input  wire logic   rst,
  pipe_ctrl_if.master bus
);

  localparam logic [REG_ADDR_W-1:0] c_reg_zero = '0;
  localparam logic [1:0] c_sel_seq  = 2'b00;
  localparam logic [1:0] c_sel_br   = 2'b01;
  localparam logic [1:0] c_sel_trap = 2'b10;

  // KILL means a fetch to the abandoned PC is still outstanding in the IFU.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    KILL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  logic       w_hz_mem, w_hz_ex, w_hz_lu, w_trap, w_redir, w_fetch_ok;
  logic       w_pc_we, w_if_kill, w_stall_inc, w_flush_inc, w_normal;
  logic [1:0] w_pc_sel;
  logic [3:0] w_en, w_stall, w_flush;

  // Hazard terms
  assign w_hz_mem   = bus.mem_valid & bus.mem_req & ~bus.mem_ready;
  assign w_hz_ex    = bus.ex_valid & bus.ex_busy;
  assign w_hz_lu    = bus.id_valid & bus.ex_valid & bus.ex_is_load &
                      (bus.ex_rd != c_reg_zero) &
                      ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                       (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));
  assign w_trap     = bus.wb_valid & bus.wb_trap;
  // A redirect waits until the older MEM/EX work is no longer frozen.
  assign w_redir    = bus.ex_valid & bus.ex_redirect & ~w_hz_mem & ~w_hz_ex;
  assign w_fetch_ok = bus.if_ready & (r_state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_pc_we     = 1'b0;
    w_pc_sel    = c_sel_seq;
    w_en        = 4'b0000;
    w_stall     = 4'b0000;
    w_flush     = 4'b0000;
    w_if_kill   = 1'b0;
    w_normal    = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    w_state_nxt = r_state;

    if (!rst) begin
      // Strict priority: the first matching hazard owns the outputs.
      if (w_trap) begin
        w_flush  = 4'b1111;
        w_pc_we  = 1'b1;
        w_pc_sel = c_sel_trap;
      end else if (w_hz_mem) begin
        w_stall = 4'b0111;
      end else if (w_hz_ex) begin
        w_stall = 4'b0011;
        w_en    = 4'b1000;
      end else if (w_redir) begin
        w_flush  = 4'b0011;
        w_en     = 4'b1100;
        w_pc_we  = 1'b1;
        w_pc_sel = c_sel_br;
      end else if (w_hz_lu) begin
        w_stall = 4'b0001;
        w_en    = 4'b1100;
      end else begin
        w_normal = 1'b1;
        w_en     = {3'b111, w_fetch_ok};
        w_pc_we  = w_fetch_ok;
      end

      w_stall_inc = ~w_trap & (w_hz_mem | w_hz_ex | w_hz_lu |
                               (w_normal & ~w_fetch_ok));
      w_flush_inc = w_trap | w_redir;

      case (r_state)
        RUN: begin
          if ((w_trap | w_redir) & ~bus.if_ready) begin
            w_state_nxt = KILL;
          end
        end
        KILL: begin
          // The returning stale word is discarded, even if a new redirect
          // happens in the same cycle.
          if (bus.if_ready) begin
            w_if_kill   = 1'b1;
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(w_stall_inc);
      r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(w_flush_inc);
    end
  end

  assign bus.pc_we          = w_pc_we;
  assign bus.pc_sel         = w_pc_sel;
  assign bus.slice_en       = w_en;
  assign bus.slice_stall    = w_stall;
  assign bus.slice_flush    = w_flush;
  assign bus.if_kill        = w_if_kill;
  assign bus.perf_stall_cnt = rst ? '0 : r_stall_cnt;
  assign bus.perf_flush_cnt = rst ? '0 : r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl: directed scenarios plus a
//            randomized run compared against a rule-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int c_raw = 5;
  localparam int c_cw  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.REG_ADDR_W(c_raw), .CNT_WIDTH(c_cw)) bus ();

  pipe_ctrl #(.REG_ADDR_W(c_raw), .CNT_WIDTH(c_cw)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // {pc_we, pc_sel, en, stall, flush, if_kill}
  logic [15:0] obs;
  assign obs = {bus.pc_we, bus.pc_sel, bus.slice_en, bus.slice_stall,
                bus.slice_flush, bus.if_kill};

  typedef struct packed {
    logic [15:0] ctl;
    logic        inc_stall;
    logic        inc_flush;
    logic        next_kill;
  } exp_t;

  // Reference: apply the priority table to the current inputs.
  function automatic exp_t predict(input bit kill);
    exp_t e = '0;
    bit mw, xw, lu, tr, rd, fetch, norm;
    if (rst) return e;
    mw = bus.mem_valid && bus.mem_req && !bus.mem_ready;
    xw = bus.ex_valid && bus.ex_busy;
    lu = bus.id_valid && bus.ex_valid && bus.ex_is_load && (bus.ex_rd != 0) &&
         ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
          (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    tr = bus.wb_valid && bus.wb_trap;
    rd = bus.ex_valid && bus.ex_redirect && !mw && !xw;
    fetch = bus.if_ready && !kill;
    norm = 0;
    if (tr)      e.ctl = {1'b1, 2'b10, 4'b0000, 4'b0000, 4'b1111, 1'b0};
    else if (mw) e.ctl = {1'b0, 2'b00, 4'b0000, 4'b0111, 4'b0000, 1'b0};
    else if (xw) e.ctl = {1'b0, 2'b00, 4'b1000, 4'b0011, 4'b0000, 1'b0};
    else if (rd) e.ctl = {1'b1, 2'b01, 4'b1100, 4'b0000, 4'b0011, 1'b0};
    else if (lu) e.ctl = {1'b0, 2'b00, 4'b1100, 4'b0001, 4'b0000, 1'b0};
    else begin
      norm  = 1;
      e.ctl = {fetch, 2'b00, 3'b111, fetch, 4'b0000, 4'b0000, 1'b0};
    end
    e.ctl[0]    = kill && bus.if_ready;
    e.inc_stall = !tr && (mw || xw || lu || (norm && !fetch));
    e.inc_flush = tr || rd;
    e.next_kill = kill ? !bus.if_ready : ((tr || rd) && !bus.if_ready);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_ready = 0; bus.id_valid = 0; bus.ex_valid = 0; bus.mem_valid = 0;
    bus.wb_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0;
    bus.id_use_rs2 = 0; bus.ex_rd = 0; bus.ex_is_load = 0; bus.ex_busy = 0;
    bus.ex_redirect = 0; bus.mem_req = 0; bus.mem_ready = 0; bus.wb_trap = 0;
  endtask

  task automatic apply_reset();
    rst = 1;
    clear_inputs();
    step();
    step();
    rst = 0;
  endtask

  task automatic set_normal();
    clear_inputs();
    bus.if_ready = 1; bus.id_valid = 1; bus.ex_valid = 1;
    bus.mem_valid = 1; bus.wb_valid = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      bus.if_ready = 1'($urandom); bus.wb_valid = 1; bus.wb_trap = 1'($urandom);
      bus.ex_valid = 1; bus.ex_redirect = 1; bus.mem_valid = 1; bus.mem_req = 1;
      @(negedge clk);
      checks++;
      if (obs !== 16'h0 || bus.perf_stall_cnt !== 0 || bus.perf_flush_cnt !== 0) begin
        failures++;
        $display("FAIL reset_outputs: got ctl=%h st=%0d fl=%0d, want all 0",
                 obs, bus.perf_stall_cnt, bus.perf_flush_cnt);
      end
      step();
    end
    rst = 0;
    clear_inputs();
    @(negedge clk);
    checks++;
    if (bus.perf_stall_cnt !== 0 || bus.perf_flush_cnt !== 0) begin
      failures++;
      $display("FAIL reset_counters: got st=%0d fl=%0d, want 0 0",
               bus.perf_stall_cnt, bus.perf_flush_cnt);
    end
    step();
  endtask

  task automatic test_normal();
    apply_reset();
    set_normal();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== {1'b1, 2'b00, 4'b1111, 4'b0000, 4'b0000, 1'b0}) begin
        failures++;
        $display("FAIL normal_flow: got %b, want %b", obs,
                 {1'b1, 2'b00, 4'b1111, 4'b0000, 4'b0000, 1'b0});
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (bus.perf_stall_cnt !== 0) begin
      failures++;
      $display("FAIL normal_stall_cnt: got %0d, want 0", bus.perf_stall_cnt);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    set_normal();
    bus.ex_is_load = 1; bus.ex_rd = 5; bus.id_rs2 = 5; bus.id_use_rs2 = 1;
    bus.id_rs1 = 3; bus.id_use_rs1 = 1;
    @(negedge clk);
    checks++;
    if (obs !== {1'b0, 2'b00, 4'b1100, 4'b0001, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL load_use: got %b, want %b", obs,
               {1'b0, 2'b00, 4'b1100, 4'b0001, 4'b0000, 1'b0});
    end
    step();
    bus.ex_is_load = 0;
    @(negedge clk);
    checks++;
    if (bus.perf_stall_cnt !== 1 || obs !== {1'b1, 2'b00, 4'b1111, 4'b0000, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL load_use_after: got cnt=%0d ctl=%b, want cnt=1 normal",
               bus.perf_stall_cnt, obs);
    end
    step();
  endtask

  task automatic test_mem_redirect();
    apply_reset();
    set_normal();
    bus.mem_req = 1; bus.mem_ready = 0; bus.ex_redirect = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== {1'b0, 2'b00, 4'b0000, 4'b0111, 4'b0000, 1'b0}) begin
        failures++;
        $display("FAIL mem_wait_cycle%0d: got %b, want %b", i, obs,
                 {1'b0, 2'b00, 4'b0000, 4'b0111, 4'b0000, 1'b0});
      end
      step();
    end
    bus.mem_ready = 1;
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 2'b01, 4'b1100, 4'b0000, 4'b0011, 1'b0}) begin
      failures++;
      $display("FAIL mem_then_redirect: got %b, want %b", obs,
               {1'b1, 2'b01, 4'b1100, 4'b0000, 4'b0011, 1'b0});
    end
    step();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (bus.perf_stall_cnt !== 3 || bus.perf_flush_cnt !== 1) begin
      failures++;
      $display("FAIL mem_redirect_counts: got st=%0d fl=%0d, want 3 1",
               bus.perf_stall_cnt, bus.perf_flush_cnt);
    end
    step();
  endtask

  task automatic test_trap();
    apply_reset();
    set_normal();
    bus.wb_trap = 1; bus.mem_req = 1; bus.mem_ready = 0;
    bus.ex_is_load = 1; bus.ex_rd = 7; bus.id_rs1 = 7; bus.id_use_rs1 = 1;
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 2'b10, 4'b0000, 4'b0000, 4'b1111, 1'b0}) begin
      failures++;
      $display("FAIL trap_priority: got %b, want %b", obs,
               {1'b1, 2'b10, 4'b0000, 4'b0000, 4'b1111, 1'b0});
    end
    step();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (bus.perf_stall_cnt !== 0 || bus.perf_flush_cnt !== 1) begin
      failures++;
      $display("FAIL trap_counts: got st=%0d fl=%0d, want 0 1",
               bus.perf_stall_cnt, bus.perf_flush_cnt);
    end
    step();
  endtask

  task automatic test_stale_fetch();
    apply_reset();
    set_normal();
    bus.ex_redirect = 1; bus.if_ready = 0;
    step();
    bus.ex_redirect = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== {1'b0, 2'b00, 4'b1110, 4'b0000, 4'b0000, 1'b0}) begin
        failures++;
        $display("FAIL kill_wait%0d: got %b, want %b", i, obs,
                 {1'b0, 2'b00, 4'b1110, 4'b0000, 4'b0000, 1'b0});
      end
      step();
    end
    bus.if_ready = 1;
    @(negedge clk);
    checks++;
    if (obs !== {1'b0, 2'b00, 4'b1110, 4'b0000, 4'b0000, 1'b1}) begin
      failures++;
      $display("FAIL kill_drop: got %b, want %b", obs,
               {1'b0, 2'b00, 4'b1110, 4'b0000, 4'b0000, 1'b1});
    end
    step();
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 2'b00, 4'b1111, 4'b0000, 4'b0000, 1'b0} ||
        bus.perf_stall_cnt !== 3 || bus.perf_flush_cnt !== 1) begin
      failures++;
      $display("FAIL kill_resume: got ctl=%b st=%0d fl=%0d, want normal 3 1",
               obs, bus.perf_stall_cnt, bus.perf_flush_cnt);
    end
    step();
  endtask

  task automatic test_wrap_and_reset_in_kill();
    apply_reset();
    set_normal();
    bus.ex_busy = 1;
    for (int i = 0; i < 15; i++) step();
    @(negedge clk);
    checks++;
    if (bus.perf_stall_cnt !== 15) begin
      failures++;
      $display("FAIL wrap_pre: got %0d, want 15", bus.perf_stall_cnt);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.perf_stall_cnt !== 0) begin
      failures++;
      $display("FAIL wrap_zero: got %0d, want 0", bus.perf_stall_cnt);
    end
    bus.ex_busy = 0; bus.ex_redirect = 1; bus.if_ready = 0;
    step();
    bus.ex_redirect = 0; bus.if_ready = 1;
    rst = 1;
    @(negedge clk);
    checks++;
    if (obs !== 16'h0) begin
      failures++;
      $display("FAIL reset_in_kill: got %b, want all 0", obs);
    end
    step();
    rst = 0;
    @(negedge clk);
    checks++;
    if (obs !== {1'b1, 2'b00, 4'b1111, 4'b0000, 4'b0000, 1'b0} ||
        bus.perf_stall_cnt !== 0 || bus.perf_flush_cnt !== 0) begin
      failures++;
      $display("FAIL after_reset_run: got ctl=%b st=%0d fl=%0d, want normal 0 0",
               obs, bus.perf_stall_cnt, bus.perf_flush_cnt);
    end
    step();
  endtask

  task automatic test_random();
    bit   m_kill = 0;
    int   m_st = 0;
    int   m_fl = 0;
    exp_t e;
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus.if_ready    = 1'($urandom);
      bus.id_valid    = ($urandom_range(0, 3) != 0);
      bus.ex_valid    = ($urandom_range(0, 3) != 0);
      bus.mem_valid   = ($urandom_range(0, 3) != 0);
      bus.wb_valid    = ($urandom_range(0, 3) != 0);
      bus.id_rs1      = 5'($urandom_range(0, 3));
      bus.id_rs2      = 5'($urandom_range(0, 3));
      bus.ex_rd       = 5'($urandom_range(0, 3));
      bus.id_use_rs1  = 1'($urandom);
      bus.id_use_rs2  = 1'($urandom);
      bus.ex_is_load  = ($urandom_range(0, 2) == 0);
      bus.ex_busy     = ($urandom_range(0, 4) == 0);
      bus.ex_redirect = ($urandom_range(0, 3) == 0);
      bus.mem_req     = 1'($urandom);
      bus.mem_ready   = ($urandom_range(0, 2) != 0);
      bus.wb_trap     = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      e = predict(m_kill);
      checks++;
      if (obs !== e.ctl) begin
        failures++;
        $display("FAIL rand_ctl[%0d]: got %b, want %b", n, obs, e.ctl);
      end
      checks++;
      if (bus.perf_stall_cnt !== c_cw'(rst ? 0 : m_st) ||
          bus.perf_flush_cnt !== c_cw'(rst ? 0 : m_fl)) begin
        failures++;
        $display("FAIL rand_cnt[%0d]: got st=%0d fl=%0d, want %0d %0d", n,
                 bus.perf_stall_cnt, bus.perf_flush_cnt,
                 rst ? 0 : m_st, rst ? 0 : m_fl);
      end
      step();
      if (rst) begin
        m_kill = 0; m_st = 0; m_fl = 0;
      end else begin
        m_kill = e.next_kill;
        m_st   = (m_st + int'(e.inc_stall)) % (1 << c_cw);
        m_fl   = (m_fl + int'(e.inc_flush)) % (1 << c_cw);
      end
    end
    rst = 0;
  endtask

  initial begin
    clear_inputs();
    step();
    test_reset();
    test_normal();
    test_load_use();
    test_mem_redirect();
    test_trap();
    test_stale_fetch();
    test_wrap_and_reset_in_kill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
